controlador_salidas: RTL

//  Output-side counterpart of the switch-input controller. Takes the binary result of the

---
 rtl/controlador_salidas_if.sv | 27 ++
 rtl/controlador_salidas.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/controlador_salidas_if.sv
`default_nettype none
// ============================================================================
// Module   : controlador_salidas_if
// Brief    : Load/status handshake and display pins of the BCD display driver.
// Revision : 1.0 - initial release
// ============================================================================
interface controlador_salidas_if #(
    parameter int WIDTH = 9
) ();
    logic             load;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [3:0]       an;
    logic [6:0]       seg;

    modport master (
        output load, value,
        input  busy, done, an, seg
    );

    modport slave (
        input  load, value,
        output busy, done, an, seg
    );
endinterface
`default_nettype wire

// File: rtl/controlador_salidas.sv
`default_nettype none
// ============================================================================
// Module   : controlador_salidas
// Brief    : Sequential binary-to-BCD converter feeding a 4-digit multiplexed
//            common-anode 7-segment display with leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_salidas #(
    parameter int WIDTH       = 9,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    controlador_salidas_if.slave   bus
);

    localparam int         RW       = $clog2(REFRESH_DIV);
    localparam logic [3:0] LAST     = 4'(WIDTH - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [15:0]      scratch_q;
    logic [15:0]      scratch_adj;
    logic [15:0]      scratch_d;
    logic [3:0]       cnt_q;
    logic [15:0]      disp_q;
    logic             busy_q;
    logic             done_q;

    logic [RW-1:0]    ref_q;
    logic [1:0]       idx_q;

    logic [3:0]       digit;
    logic             blank;

    // Shift-add-3 step: correct every nibble >= 5 before the joint left shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int n = 0; n < 4; n++) begin
            if (scratch_q[4*n +: 4] >= 4'd5) begin
                scratch_adj[4*n +: 4] = scratch_q[4*n +: 4] + 4'd3;
            end
        end
        {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        shreg_q   <= bus.value;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shreg_q   <= shreg_d;
                    cnt_q     <= cnt_q + 4'd1;
                    if (cnt_q == LAST) begin
                        disp_q  <= scratch_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            idx_q <= '0;
        end else if (ref_q == REF_LAST) begin
            ref_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            ref_q <= ref_q + RW'(1);
        end
    end

    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        digit = disp_q[3:0];
        blank = 1'b0;
        case (idx_q)
            2'd0: digit = disp_q[3:0];
            2'd1: begin
                digit = disp_q[7:4];
                blank = (disp_q[15:4] == 12'd0);
            end
            2'd2: begin
                digit = disp_q[11:8];
                blank = (disp_q[15:8] == 8'd0);
            end
            default: begin
                digit = disp_q[15:12];
                blank = (disp_q[15:12] == 4'd0);
            end
        endcase
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign bus.an   = blank ? 4'hF : ~(4'b0001 << idx_q);
    assign bus.seg  = blank ? 7'h7F : seg_decode(digit);
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
`default_nettype wire
